operand_sweep_capture: RTL and testbench

- Sequential sweep stage wrapped around a 2-bit-operand combinational function block.
- Upstream role: drives operands a_out[1:0] and b_out[1:0] through all 16 combinations in order.
- Downstream role: samples the 2-bit result c_in after a programmable settle time and packs all 16 results into one 32-bit result vector.
- Also emits a per-point sample stream for on-board display and logging.

---
 rtl/sweep_pkg.sv | 15 +
 rtl/sweep_settle_timer.sv | 35 +++
 rtl/operand_sweep_capture.sv | 110 +++++++++++
 tb/tb_operand_sweep_capture.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared constants and FSM state encoding for the operand sweep capture stage.
package sweep_pkg;

  localparam int unsigned NUM_POINTS = 16;
  localparam int unsigned OPW        = 2;
  localparam int unsigned IDXW       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-time down-counter: load arms it, expire_o flags the last settle cycle.
module sweep_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/operand_sweep_capture.sv
// Sweeps 2-bit operands a/b through all 16 combinations, captures the settled
// result c_in of each point into a packed 32-bit vector and a sample stream.
module operand_sweep_capture
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [OPW-1:0]             a_out,
  output logic [OPW-1:0]             b_out,
  input  logic [OPW-1:0]             c_in,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_POINTS*OPW-1:0]  result,
  output logic                       sample_valid,
  output logic [IDXW-1:0]            sample_idx,
  output logic [OPW-1:0]             sample_c
);

  state_t                     state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [NUM_POINTS*OPW-1:0]  result_q, result_d;
  logic [IDXW-1:0]            sidx_q, sidx_d;
  logic [OPW-1:0]             sc_q, sc_d;
  logic                       sv_q, sv_d;
  logic                       tmr_load, tmr_en, tmr_expire;

  // Up-counting settle count replaced by a down-counter reloaded on SETTLE
  // entry; expiry still falls on the SETTLE_CYCLES-th SETTLE cycle.
  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    sidx_d   = sidx_q;
    sc_d     = sc_q;
    sv_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d    = '0;
          result_d = '0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        result_d[int'(idx_q) * OPW +: OPW] = c_in;
        sidx_d = idx_q;
        sc_d   = c_in;
        sv_d   = 1'b1;
        if (idx_q == IDXW'(NUM_POINTS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 4'd1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      sidx_q   <= '0;
      sc_q     <= '0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      sidx_q   <= sidx_d;
      sc_q     <= sc_d;
      sv_q     <= sv_d;
    end
  end

  assign a_out        = idx_q[3:2];
  assign b_out        = idx_q[1:0];
  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done         = (state_q == ST_DONE);
  assign result       = result_q;
  assign sample_valid = sv_q;
  assign sample_idx   = sidx_q;
  assign sample_c     = sc_q;

endmodule

// File: tb/tb_operand_sweep_capture.sv
// Scoreboard bench: u_dut2 (settle 2, c = a^b with optional settle glitches),
// u_dut1 (settle 1, c tied high, start held high for back-to-back sweeps).
module tb_operand_sweep_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start1;
  logic [1:0]  a2, b2, c2, a1, b1, c1;
  logic        busy2, done2, sv2, busy1, done1, sv1;
  logic [31:0] res2, res1;
  logic [3:0]  sidx2, sidx1;
  logic [1:0]  sc2, sc1;

  int checks   = 0;
  int failures = 0;

  logic [5:0] q2[$];
  logic [5:0] q1[$];
  logic [5:0] e2, e1;
  bit         glitch = 1'b0;
  int         ph = 0;

  always #5 clk = ~clk;

  // During settle cycles the function block output is deliberately wrong.
  always_comb c2 = (glitch && ph != 2) ? ~(a2 ^ b2) : (a2 ^ b2);
  assign c1 = 2'b11;

  operand_sweep_capture #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2), .c_in(c2),
    .busy(busy2), .done(done2), .result(res2), .sample_valid(sv2),
    .sample_idx(sidx2), .sample_c(sc2)
  );

  operand_sweep_capture #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .c_in(c1),
    .busy(busy1), .done(done1), .result(res1), .sample_valid(sv1),
    .sample_idx(sidx1), .sample_c(sc1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sv2) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2_unexpected_sample: got idx %0d, expected no sample", sidx2);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_sample_idx", 32'(sidx2), 32'(e2[5:2]));
        chk("dut2_sample_c", 32'(sc2), 32'(e2[1:0]));
        chk("dut2_result_field", 32'(res2[int'(e2[5:2]) * 2 +: 2]), 32'(e2[1:0]));
      end
    end
    if (sv1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_sample: got idx %0d, expected no sample", sidx1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_sample_idx", 32'(sidx1), 32'(e1[5:2]));
        chk("dut1_sample_c", 32'(sc1), 32'(e1[1:0]));
      end
    end
  end

  task automatic push_xor();
    logic [3:0] iv;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      q2.push_back({iv, iv[3:2] ^ iv[1:0]});
    end
  endtask

  // Called at posedge+1; issues start and follows the sweep edge by edge.
  task automatic run_sweep2(input string tag, input int pulse_at);
    int done_edge = -1;
    int busy_cnt  = 0;
    int op_err    = 0;
    logic [3:0] ei;
    push_xor();
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int e = 0; e < 56; e++) begin
      ph = e % 3;
      if (busy2) busy_cnt++;
      if (done2 && done_edge < 0) done_edge = e;
      if (e < 48) begin
        ei = 4'(e / 3);
        if (a2 !== ei[3:2] || b2 !== ei[1:0]) op_err++;
      end
      start2 = (pulse_at > 0 && e == pulse_at - 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    glitch = 1'b0;
    chk({tag, "_done_edge"}, done_edge, 32'd48);
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd48);
    chk({tag, "_operand_order_errors"}, op_err, 32'd0);
    chk({tag, "_result"}, res2, 32'h1B4E_B1E4);
    chk({tag, "_done_held"}, 32'(done2), 32'd1);
    chk({tag, "_samples_outstanding"}, q2.size(), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int done_edge1;
    rst    = 1'b1;
    start2 = 1'b0;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", res2, 32'd0);
    chk("reset_operands", {28'd0, a2, b2}, 32'd0);
    chk("reset_flags", {29'd0, busy2, done2, sv2}, 32'd0);
    chk("reset_sample", {26'd0, sidx2, sc2}, 32'd0);
    chk("reset_dut1_flags", {30'd0, busy1, done1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_sweep2("sweep1", 0);
    run_sweep2("busy_start", 20);

    // Asynchronous reset mid-clock while idx=7 is settling.
    push_xor();
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (22) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_result", res2, 32'd0);
    chk("midrst_operands", {28'd0, a2, b2}, 32'd0);
    chk("midrst_flags", {29'd0, busy2, done2, sv2}, 32'd0);
    chk("midrst_sample", {26'd0, sidx2, sc2}, 32'd0);
    chk("midrst_samples_left", q2.size(), 32'd9);
    q2.delete();
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_idle_busy", {30'd0, busy2, done2}, 32'd0);
    run_sweep2("after_rst", 0);

    glitch = 1'b1;
    run_sweep2("glitch", 0);

    // Back-to-back sweeps with start held high, settle of one cycle.
    for (int i = 0; i < 32; i++) q1.push_back({4'(i % 16), 2'b11});
    done_cnt   = 0;
    done_edge1 = -1;
    start1 = 1'b1;
    @(posedge clk); #1;
    for (int e = 0; e < 66; e++) begin
      if (e < 64 && done1) done_cnt++;
      if (done1 && done_edge1 < 0) done_edge1 = e;
      if (e == 32) chk("held_result_full", res1, 32'hFFFF_FFFF);
      if (e == 33) chk("held_result_cleared", res1, 32'd0);
      if (e == 65) begin
        chk("held_second_done", 32'(done1), 32'd1);
        start1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("held_done_edge", done_edge1, 32'd32);
    chk("held_done_cycles", done_cnt, 32'd1);
    chk("held_final_done", 32'(done1), 32'd1);
    chk("held_final_result", res1, 32'hFFFF_FFFF);
    chk("held_samples_outstanding", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
